// File: rtl/vram_pkg.sv
// Shared types for the video-memory shadow: the fetch address, the CPU write
// buffer entry, the arbiter states and the screen bank numbers.
package vram_pkg;

   typedef logic [14:0] vram_addr_t;

   typedef struct packed {
      vram_addr_t  addr;
      logic [7:0]  data;
   } wr_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_ISSUE,
      ST_RD_CAP
   } arb_state_t;

   localparam logic [2:0] BANK_SCR0 = 3'd5;
   localparam logic [2:0] BANK_SCR1 = 3'd7;

endpackage

// File: rtl/vram_spram.sv
// Single-port 32K x 8 shadow RAM with a registered read (1-cycle latency).
// Ports: clk_sys, i_we, i_addr (15b), i_din (8b) -> o_dout (8b).
module vram_spram
   import vram_pkg::*;
(
   input  logic       clk_sys,
   input  logic       i_we,
   input  vram_addr_t i_addr,
   input  logic [7:0] i_din,
   output logic [7:0] o_dout
);

   logic [7:0] r_mem [0:32767];
   logic [7:0] r_q;

   // Reads and writes never share a cycle, so read-during-write
   // behaviour is irrelevant.
   always_ff @(posedge clk_sys) begin
      if (i_we)
         r_mem[i_addr] <= i_din;
      r_q <= r_mem[i_addr];
   end

   assign o_dout = r_q;

endmodule

// File: rtl/vram_shadow.sv
// Shadow of RAM banks 5/7 fed by snooped CPU writes, answering video fetches.
// Ports: clk_sys, reset, ce_7mn, vram_addr -> vram_dout; cpu_addr, cpu_din,
// nMREQ, nWR, m128, page_ram (write snoop); wr_drop, fifo_level (status).
module vram_shadow
   import vram_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int MIN_RATIO  = 3
)(
   input  logic                          clk_sys,
   input  logic                          reset,
   input  logic                          ce_7mn,
   input  logic [14:0]                   vram_addr,
   output logic [7:0]                    vram_dout,
   input  logic [15:0]                   cpu_addr,
   input  logic [7:0]                    cpu_din,
   input  logic                          nMREQ,
   input  logic                          nWR,
   input  logic                          m128,
   input  logic [2:0]                    page_ram,
   output logic                          wr_drop,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   arb_state_t r_state, w_nstate;

   logic          w_wr;
   logic          r_old_wr;
   logic          w_wr_edge;
   logic          w_cap_vld;
   wr_entry_t     w_cap_entry;

   wr_entry_t     r_fifo [FIFO_DEPTH];
   logic [PW-1:0] r_wptr, r_rptr;
   logic [LW-1:0] r_level;
   logic          w_full, w_empty;
   logic          w_push, w_pop, w_drop;
   wr_entry_t     w_head;

   logic          w_ram_we;
   vram_addr_t    w_ram_addr;
   logic [7:0]    w_ram_q;
   logic          w_cap;

   logic [7:0]    r_dout;
   logic          r_wr_drop;

   assign w_wr      = ~nMREQ & ~nWR;
   assign w_wr_edge = w_wr & ~r_old_wr;

   // Only writes landing in a screen bank are shadowed.
   always_comb begin
      w_cap_vld        = 1'b0;
      w_cap_entry.addr = {1'b0, cpu_addr[13:0]};
      w_cap_entry.data = cpu_din;
      unique case (1'b1)
         cpu_addr[15:14] == 2'b01: begin
            w_cap_vld = 1'b1;
         end
         cpu_addr[15:14] == 2'b11 && m128 && page_ram == BANK_SCR0: begin
            w_cap_vld = 1'b1;
         end
         cpu_addr[15:14] == 2'b11 && m128 && page_ram == BANK_SCR1: begin
            w_cap_vld        = 1'b1;
            w_cap_entry.addr = {1'b1, cpu_addr[13:0]};
         end
         default: w_cap_vld = 1'b0;
      endcase
   end

   assign w_full  = r_level == LW'(FIFO_DEPTH);
   assign w_empty = r_level == '0;
   assign w_head  = r_fifo[r_rptr];

   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push = w_wr_edge & w_cap_vld & (~w_full | w_pop);
   assign w_drop = w_wr_edge & w_cap_vld & w_full & ~w_pop;

   always_comb begin
      w_nstate   = r_state;
      w_ram_we   = 1'b0;
      w_ram_addr = w_head.addr;
      w_pop      = 1'b0;
      w_cap      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (ce_7mn) begin
               w_nstate = ST_RD_ISSUE;
            end else if (!w_empty) begin
               w_ram_we = 1'b1;
               w_pop    = 1'b1;
            end
         end
         ST_RD_ISSUE: begin
            w_ram_addr = vram_addr;
            // A too-early enable restarts the read on the new address.
            w_nstate   = ce_7mn ? ST_RD_ISSUE : ST_RD_CAP;
         end
         ST_RD_CAP: begin
            w_cap = 1'b1;
            if (!w_empty) begin
               w_ram_we = 1'b1;
               w_pop    = 1'b1;
            end
            w_nstate = ce_7mn ? ST_RD_ISSUE : ST_IDLE;
         end
         default: w_nstate = ST_IDLE;
      endcase
   end

   vram_spram u_ram (
      .clk_sys (clk_sys),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_din   (w_head.data),
      .o_dout  (w_ram_q)
   );

   always_ff @(posedge clk_sys) begin
      if (w_push)
         r_fifo[r_wptr] <= w_cap_entry;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_old_wr  <= 1'b0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_level   <= '0;
         r_dout    <= '0;
         r_wr_drop <= 1'b0;
      end else begin
         r_state  <= w_nstate;
         r_old_wr <= w_wr;
         if (w_push)
            r_wptr <= r_wptr + PW'(1);
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         if (w_cap)
            r_dout <= w_ram_q;
         if (w_drop)
            r_wr_drop <= 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset && r_state == ST_RD_ISSUE)
         assert (!ce_7mn)
            else $error("ce_7mn closer than MIN_RATIO=%0d cycles", MIN_RATIO);
   end

   assign vram_dout  = r_dout;
   assign wr_drop    = r_wr_drop;
   assign fifo_level = r_level;

endmodule

// File: tb/tb_vram_shadow.sv
// Directed + randomized bench for vram_shadow against a byte-array model
// of the two screen pages built from the CPU address decode rules.
module tb_vram_shadow;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ce_7mn;
   logic [14:0] vram_addr;
   logic [7:0]  vram_dout;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic        nMREQ, nWR, m128;
   logic [2:0]  page_ram;
   logic        wr_drop;
   logic [2:0]  fifo_level;

   int checks = 0;
   int errors = 0;

   logic [7:0] mdl [0:32767];
   int         wlist [$];

   vram_shadow #(.FIFO_DEPTH(4), .MIN_RATIO(3)) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ce_7mn     (ce_7mn),
      .vram_addr  (vram_addr),
      .vram_dout  (vram_dout),
      .cpu_addr   (cpu_addr),
      .cpu_din    (cpu_din),
      .nMREQ      (nMREQ),
      .nWR        (nWR),
      .m128       (m128),
      .page_ram   (page_ram),
      .wr_drop    (wr_drop),
      .fifo_level (fifo_level)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Screen-page index for a CPU address, or -1 when not shadowed.
   function automatic int map_addr(input int a, input bit m, input int pg);
      int region = a / 16384;
      int off    = a % 16384;
      if (region == 1) return off;
      if (region == 3 && m && pg == 5) return off;
      if (region == 3 && m && pg == 7) return 16384 + off;
      return -1;
   endfunction

   // One CPU write cycle; lvl is the FIFO level right after the strobe edge.
   task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d,
                         output logic [2:0] lvl);
      cpu_addr = a;
      cpu_din  = d;
      nMREQ    = 1'b0;
      nWR      = 1'b0;
      tick();
      lvl   = fifo_level;
      nMREQ = 1'b1;
      nWR   = 1'b1;
      tick();
   endtask

   task automatic wait_empty();
      int n = 0;
      while (fifo_level != 0 && n < 40) begin
         tick();
         n++;
      end
      chk("drain", fifo_level, 0);
   endtask

   task automatic fetch(input logic [14:0] a, output logic [7:0] d);
      ce_7mn    = 1'b1;
      vram_addr = a;
      tick();
      ce_7mn = 1'b0;
      tick();
      tick();
      d = vram_dout;
   endtask

   task automatic wr_mdl(input logic [15:0] a, input logic [7:0] d);
      logic [2:0] l;
      int idx;
      idx = map_addr(int'(a), m128, int'(page_ram));
      cpu_wr(a, d, l);
      chk("wr_level", l, (idx >= 0) ? 1 : 0);
      if (idx >= 0) begin
         mdl[idx] = d;
         wlist.push_back(idx);
      end
      wait_empty();
   endtask

   initial begin
      logic [7:0] d;
      logic [2:0] l;
      reset     = 1'b1;
      ce_7mn    = 1'b0;
      vram_addr = '0;
      cpu_addr  = '0;
      cpu_din   = '0;
      nMREQ     = 1'b1;
      nWR       = 1'b1;
      m128      = 1'b0;
      page_ram  = '0;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_dout", vram_dout, 0);
      chk("rst_drop", wr_drop, 0);
      chk("rst_level", fifo_level, 0);

      // Basic capture and exact 2-cycle fetch latency
      wr_mdl(16'h4000, 8'hA5);
      ce_7mn    = 1'b1;
      vram_addr = 15'h0000;
      tick();
      ce_7mn = 1'b0;
      tick();
      chk("lat_early", vram_dout, 0);
      tick();
      chk("lat_2cyc", vram_dout, 8'hA5);

      // 128K bank mapping
      m128     = 1'b1;
      page_ram = 3'd7;
      wr_mdl(16'hC123, 8'h3C);
      fetch(15'h4123, d);
      chk("bank7", d, 8'h3C);
      page_ram = 3'd5;
      wr_mdl(16'hC123, 8'h77);
      fetch(15'h0123, d);
      chk("bank5", d, 8'h77);
      fetch(15'h4123, d);
      chk("bank7_keep", d, 8'h3C);
      page_ram = 3'd3;
      wr_mdl(16'hC123, 8'hEE);
      fetch(15'h0123, d);
      chk("bank3_ignored", d, 8'h77);

      // Randomized writes over all regions and mappings
      for (int i = 0; i < 24; i++) begin
         int pick;
         logic [15:0] a;
         a        = 16'($urandom);
         m128     = 1'($urandom);
         pick     = $urandom_range(0, 3);
         page_ram = (pick == 0) ? 3'd5 : (pick == 1) ? 3'd7 : 3'($urandom);
         wr_mdl(a, 8'($urandom));
         if (wlist.size() > 0) begin
            int k = wlist[$urandom_range(0, wlist.size() - 1)];
            fetch(15'(k), d);
            chk("rand_fetch", d, mdl[k]);
         end
      end
      m128     = 1'b0;
      page_ram = 3'd0;

      // Fetch priority with writes interleaved, ce every 4 cycles
      for (int t = 0; t < 6; t++) begin
         int fa;
         fa        = (t % 3 == 0) ? 0 : (t % 3 == 1) ? 16'h4123 : 16'h0123;
         ce_7mn    = 1'b1;
         vram_addr = 15'(fa);
         cpu_addr  = 16'(16'h7000 + 2 * t);
         cpu_din   = 8'(8'h20 + 2 * t);
         nMREQ     = 1'b0;
         nWR       = 1'b0;
         tick();
         ce_7mn = 1'b0;
         nMREQ  = 1'b1;
         nWR    = 1'b1;
         tick();
         chk("prio_lvl_issue", fifo_level, 1);
         cpu_addr = 16'(16'h7001 + 2 * t);
         cpu_din  = 8'(8'h21 + 2 * t);
         nMREQ    = 1'b0;
         nWR      = 1'b0;
         tick();
         chk("prio_lvl_pushpop", fifo_level, 1);
         chk("prio_fetch", vram_dout, mdl[fa]);
         nMREQ = 1'b1;
         nWR   = 1'b1;
         tick();
         chk("prio_lvl_idle", fifo_level, 0);
         mdl[16'h3000 + 2 * t]     = 8'(8'h20 + 2 * t);
         mdl[16'h3000 + 2 * t + 1] = 8'(8'h21 + 2 * t);
      end
      for (int k = 0; k < 12; k += 5) begin
         fetch(15'(16'h3000 + k), d);
         chk("prio_wdata", d, mdl[16'h3000 + k]);
      end

      // Strobe held low: one push, data sampled at the edge
      cpu_addr = 16'h5555;
      cpu_din  = 8'h11;
      nMREQ    = 1'b0;
      nWR      = 1'b0;
      tick();
      chk("strobe_push", fifo_level, 1);
      cpu_din = 8'h22;
      begin
         int extra = 0;
         for (int i = 0; i < 9; i++) begin
            tick();
            if (fifo_level != 0) extra++;
         end
         chk("strobe_once", extra, 0);
      end
      nMREQ = 1'b1;
      nWR   = 1'b1;
      tick();
      mdl[16'h1555] = 8'h11;
      fetch(15'h1555, d);
      chk("strobe_data", d, 8'h11);

      // Overflow: ce every 3rd cycle, a write edge every 2nd
      chk("pre_ovf_drop", wr_drop, 0);
      for (int k = 0; k < 16; k++)
         wr_mdl(16'(16'h6000 + 3 * k), 8'(8'h40 + k));
      begin
         int idx = 0;
         int lost = 0;
         for (int c = 0; c < 36; c++) begin
            ce_7mn    = (c % 3 == 0);
            vram_addr = 15'h2003;
            if (c % 2 == 0 && idx < 16) begin
               cpu_addr = (idx < 2) ? 16'h6000 : 16'(16'h6000 + 3 * idx);
               cpu_din  = 8'(8'hC0 + idx);
               nMREQ    = 1'b0;
               nWR      = 1'b0;
               idx++;
            end else begin
               nMREQ = 1'b1;
               nWR   = 1'b1;
            end
            tick();
         end
         ce_7mn = 1'b0;
         nMREQ  = 1'b1;
         nWR    = 1'b1;
         tick();
         wait_empty();
         chk("ovf_drop", wr_drop, 1);
         fetch(15'h2003, d);
         chk("ovf_untouched", d, 8'h41);
         fetch(15'h2000, d);
         chk("ovf_order", d, 8'hC1);
         fetch(15'h2006, d);
         chk("ovf_first2", d, 8'hC2);
         fetch(15'h2009, d);
         chk("ovf_first3", d, 8'hC3);
         for (int k = 4; k < 16; k++) begin
            fetch(15'(16'h2000 + 3 * k), d);
            chk("ovf_old_or_new",
                (d == 8'(8'h40 + k)) || (d == 8'(8'hC0 + k)), 1);
            if (d == 8'(8'h40 + k)) lost++;
         end
         chk("ovf_some_lost", lost > 0, 1);
      end

      // Reset with writes still queued
      for (int k = 0; k < 8; k++)
         wr_mdl(16'(16'h5000 + 5 * k), 8'(8'h10 + k));
      begin
         int idx = 0;
         int nland = 0;
         bit prefix = 1'b1;
         bit gap = 1'b0;
         for (int c = 0; c < 16; c++) begin
            ce_7mn    = (c % 3 == 0);
            vram_addr = 15'h0000;
            if (c % 2 == 0 && idx < 8) begin
               cpu_addr = 16'(16'h5000 + 5 * idx);
               cpu_din  = 8'(8'h80 + idx);
               nMREQ    = 1'b0;
               nWR      = 1'b0;
               idx++;
            end else begin
               nMREQ = 1'b1;
               nWR   = 1'b1;
            end
            tick();
         end
         ce_7mn = 1'b0;
         nMREQ  = 1'b1;
         nWR    = 1'b1;
         chk("rst_pre_queued", fifo_level >= 2, 1);
         reset = 1'b1;
         tick();
         reset = 1'b0;
         chk("mid_rst_level", fifo_level, 0);
         chk("mid_rst_dout", vram_dout, 0);
         chk("mid_rst_drop", wr_drop, 0);
         for (int k = 0; k < 8; k++) begin
            fetch(15'(16'h1000 + 5 * k), d);
            chk("rst_old_or_new",
                (d == 8'(8'h10 + k)) || (d == 8'(8'h80 + k)), 1);
            if (d == 8'(8'h80 + k)) begin
               nland++;
               if (gap) prefix = 1'b0;
            end else begin
               gap = 1'b1;
            end
         end
         chk("rst_in_order", prefix, 1);
         chk("rst_tail_lost", nland < 8, 1);
      end
      tick();
      chk("final_level", fifo_level, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
